// File: rtl/tcp_msg_poller_sched.sv
// rtl/tcp_msg_poller_sched.sv - per-flow rx data-ready poller: dequeue, read request/pointers, notify or requeue
// One flowid is in flight at a time; all outputs except the dequeue ready are registered.
package tcp_msg_poller_pkg;
  localparam int MAX_FLOW_CNT    = 256;
  localparam int FLOWID_W        = $clog2(MAX_FLOW_CNT);
  localparam int MSG_SRC_X_WIDTH = 8;
  localparam int MSG_SRC_Y_WIDTH = 8;
  localparam int NOC_FBITS_WIDTH = 4;
  localparam int MSG_LEN_W       = 10;

  typedef struct packed {
    logic [MSG_LEN_W-1:0]       length;
    logic [MSG_SRC_X_WIDTH-1:0] dst_x;
    logic [MSG_SRC_Y_WIDTH-1:0] dst_y;
    logic [NOC_FBITS_WIDTH-1:0] dst_fbits;
  } msg_req_mem_struct;
endpackage

module tcp_msg_poller_sched
  import tcp_msg_poller_pkg::*;
#(
  parameter int POLLER_PTR_W = 0,
  // 0 selects the buffer offset width the request-memory length field is built with
  localparam int PTR_W = (POLLER_PTR_W == 0) ? MSG_LEN_W : POLLER_PTR_W
) (
  input  logic                       clk,
  input  logic                       rst,

  input  logic                       msg_req_q_poller_rd_req_val,
  input  logic [FLOWID_W-1:0]        msg_req_q_poller_rd_req_data,
  output logic                       poller_msg_req_q_rd_req_rdy,

  output logic                       poller_msg_req_mem_rd_req_val,
  output logic [FLOWID_W-1:0]        poller_msg_req_mem_rd_req_addr,
  input  logic                       msg_req_mem_poller_rd_req_rdy,

  input  logic                       msg_req_mem_poller_rd_resp_val,
  input  msg_req_mem_struct          msg_req_mem_poller_rd_resp_data,
  output logic                       poller_msg_req_mem_rd_resp_rdy,

  output logic                       poller_ptr_rd_req_val,
  output logic [FLOWID_W-1:0]        poller_ptr_rd_req_flowid,
  input  logic                       ptr_poller_rd_req_rdy,

  input  logic                       ptr_poller_rd_resp_val,
  input  logic [PTR_W:0]             ptr_poller_rd_resp_head,
  input  logic [PTR_W:0]             ptr_poller_rd_resp_commit,
  output logic                       poller_ptr_rd_resp_rdy,

  output logic                       poller_dst_notif_val,
  output logic [FLOWID_W-1:0]        poller_dst_notif_flowid,
  output logic [PTR_W-1:0]           poller_dst_notif_len,
  output logic [MSG_SRC_X_WIDTH-1:0] poller_dst_notif_dst_x,
  output logic [MSG_SRC_Y_WIDTH-1:0] poller_dst_notif_dst_y,
  output logic [NOC_FBITS_WIDTH-1:0] poller_dst_notif_dst_fbits,
  input  logic                       dst_poller_notif_rdy,

  output logic                       poller_msg_req_q_wr_req_val,
  output logic [FLOWID_W-1:0]        poller_msg_req_q_wr_req_data,
  input  logic                       msg_req_q_poller_wr_req_rdy,

  output logic                       poller_active_bitvec_clear_req_val,
  output logic [FLOWID_W-1:0]        poller_active_bitvec_clear_req_flowid
);

  typedef enum logic [2:0] {
    S_IDLE, S_READ_REQ, S_WAIT_RESP, S_DECIDE, S_NOTIFY, S_REQUEUE
  } state_t;

  state_t                     state;
  logic [FLOWID_W-1:0]        flowid_r;
  logic [PTR_W-1:0]           len_r;
  logic [MSG_SRC_X_WIDTH-1:0] dst_x_r;
  logic [MSG_SRC_Y_WIDTH-1:0] dst_y_r;
  logic [NOC_FBITS_WIDTH-1:0] dst_fbits_r;
  logic [PTR_W:0]             head_r;
  logic [PTR_W:0]             commit_r;
  logic [PTR_W:0]             avail;
  logic                       mem_req_done, ptr_req_done;
  logic                       mem_resp_fire, ptr_resp_fire;
  logic                       mem_resp_done, ptr_resp_done;

  // A request is done once it was accepted earlier or is accepted this cycle
  assign mem_req_done  = ~poller_msg_req_mem_rd_req_val | msg_req_mem_poller_rd_req_rdy;
  assign ptr_req_done  = ~poller_ptr_rd_req_val | ptr_poller_rd_req_rdy;
  assign mem_resp_fire = poller_msg_req_mem_rd_resp_rdy & msg_req_mem_poller_rd_resp_val;
  assign ptr_resp_fire = poller_ptr_rd_resp_rdy & ptr_poller_rd_resp_val;
  assign mem_resp_done = ~poller_msg_req_mem_rd_resp_rdy | msg_req_mem_poller_rd_resp_val;
  assign ptr_resp_done = ~poller_ptr_rd_resp_rdy | ptr_poller_rd_resp_val;

  // Wrap bit makes the modular difference exact for a completely full buffer
  assign avail = commit_r - head_r;

  assign poller_msg_req_q_rd_req_rdy           = (state == S_IDLE) & ~rst;
  assign poller_msg_req_mem_rd_req_addr        = flowid_r;
  assign poller_ptr_rd_req_flowid              = flowid_r;
  assign poller_dst_notif_flowid               = flowid_r;
  assign poller_dst_notif_len                  = len_r;
  assign poller_dst_notif_dst_x                = dst_x_r;
  assign poller_dst_notif_dst_y                = dst_y_r;
  assign poller_dst_notif_dst_fbits            = dst_fbits_r;
  assign poller_msg_req_q_wr_req_data          = flowid_r;
  assign poller_active_bitvec_clear_req_flowid = flowid_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                              <= S_IDLE;
      flowid_r                           <= '0;
      len_r                              <= '0;
      dst_x_r                            <= '0;
      dst_y_r                            <= '0;
      dst_fbits_r                        <= '0;
      head_r                             <= '0;
      commit_r                           <= '0;
      poller_msg_req_mem_rd_req_val      <= 1'b0;
      poller_ptr_rd_req_val              <= 1'b0;
      poller_msg_req_mem_rd_resp_rdy     <= 1'b0;
      poller_ptr_rd_resp_rdy             <= 1'b0;
      poller_dst_notif_val               <= 1'b0;
      poller_msg_req_q_wr_req_val        <= 1'b0;
      poller_active_bitvec_clear_req_val <= 1'b0;
    end else begin
      poller_active_bitvec_clear_req_val <= 1'b0;
      case (state)
        S_IDLE: begin
          if (msg_req_q_poller_rd_req_val) begin
            flowid_r                      <= msg_req_q_poller_rd_req_data;
            poller_msg_req_mem_rd_req_val <= 1'b1;
            poller_ptr_rd_req_val         <= 1'b1;
            state                         <= S_READ_REQ;
          end
        end
        S_READ_REQ: begin
          if (msg_req_mem_poller_rd_req_rdy) poller_msg_req_mem_rd_req_val <= 1'b0;
          if (ptr_poller_rd_req_rdy)         poller_ptr_rd_req_val         <= 1'b0;
          if (mem_req_done && ptr_req_done) begin
            poller_msg_req_mem_rd_resp_rdy <= 1'b1;
            poller_ptr_rd_resp_rdy         <= 1'b1;
            state                          <= S_WAIT_RESP;
          end
        end
        S_WAIT_RESP: begin
          if (mem_resp_fire) begin
            len_r                          <= PTR_W'(msg_req_mem_poller_rd_resp_data.length);
            dst_x_r                        <= msg_req_mem_poller_rd_resp_data.dst_x;
            dst_y_r                        <= msg_req_mem_poller_rd_resp_data.dst_y;
            dst_fbits_r                    <= msg_req_mem_poller_rd_resp_data.dst_fbits;
            poller_msg_req_mem_rd_resp_rdy <= 1'b0;
          end
          if (ptr_resp_fire) begin
            head_r                 <= ptr_poller_rd_resp_head;
            commit_r               <= ptr_poller_rd_resp_commit;
            poller_ptr_rd_resp_rdy <= 1'b0;
          end
          if (mem_resp_done && ptr_resp_done) state <= S_DECIDE;
        end
        S_DECIDE: begin
          if (avail >= {1'b0, len_r}) begin
            poller_dst_notif_val <= 1'b1;
            state                <= S_NOTIFY;
          end else begin
            poller_msg_req_q_wr_req_val <= 1'b1;
            state                       <= S_REQUEUE;
          end
        end
        S_NOTIFY: begin
          if (dst_poller_notif_rdy) begin
            poller_dst_notif_val               <= 1'b0;
            poller_active_bitvec_clear_req_val <= 1'b1;
            state                              <= S_IDLE;
          end
        end
        S_REQUEUE: begin
          if (msg_req_q_poller_wr_req_rdy) begin
            poller_msg_req_q_wr_req_val <= 1'b0;
            state                       <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tcp_msg_poller_sched.sv
// tb/tb_tcp_msg_poller_sched.sv - scoreboard bench for tcp_msg_poller_sched
module tb_tcp_msg_poller_sched;
  import tcp_msg_poller_pkg::*;

  localparam int PW = 10;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic                       q_rd_val, q_rd_rdy;
  logic [FLOWID_W-1:0]        q_rd_data;
  logic                       mem_req_val, mem_req_rdy;
  logic [FLOWID_W-1:0]        mem_req_addr;
  logic                       mem_resp_val, mem_resp_rdy;
  msg_req_mem_struct          mem_resp_data;
  logic                       ptr_req_val, ptr_req_rdy;
  logic [FLOWID_W-1:0]        ptr_req_flowid;
  logic                       ptr_resp_val, ptr_resp_rdy;
  logic [PW:0]                ptr_head, ptr_commit;
  logic                       notif_val, notif_rdy;
  logic [FLOWID_W-1:0]        notif_flowid;
  logic [PW-1:0]              notif_len;
  logic [MSG_SRC_X_WIDTH-1:0] notif_x;
  logic [MSG_SRC_Y_WIDTH-1:0] notif_y;
  logic [NOC_FBITS_WIDTH-1:0] notif_fb;
  logic                       wr_val, wr_rdy;
  logic [FLOWID_W-1:0]        wr_data;
  logic                       clr_val;
  logic [FLOWID_W-1:0]        clr_fid;

  tcp_msg_poller_sched #(.POLLER_PTR_W(PW)) dut (
    .clk                                   (clk),
    .rst                                   (rst),
    .msg_req_q_poller_rd_req_val           (q_rd_val),
    .msg_req_q_poller_rd_req_data          (q_rd_data),
    .poller_msg_req_q_rd_req_rdy           (q_rd_rdy),
    .poller_msg_req_mem_rd_req_val         (mem_req_val),
    .poller_msg_req_mem_rd_req_addr        (mem_req_addr),
    .msg_req_mem_poller_rd_req_rdy         (mem_req_rdy),
    .msg_req_mem_poller_rd_resp_val        (mem_resp_val),
    .msg_req_mem_poller_rd_resp_data       (mem_resp_data),
    .poller_msg_req_mem_rd_resp_rdy        (mem_resp_rdy),
    .poller_ptr_rd_req_val                 (ptr_req_val),
    .poller_ptr_rd_req_flowid              (ptr_req_flowid),
    .ptr_poller_rd_req_rdy                 (ptr_req_rdy),
    .ptr_poller_rd_resp_val                (ptr_resp_val),
    .ptr_poller_rd_resp_head               (ptr_head),
    .ptr_poller_rd_resp_commit             (ptr_commit),
    .poller_ptr_rd_resp_rdy                (ptr_resp_rdy),
    .poller_dst_notif_val                  (notif_val),
    .poller_dst_notif_flowid               (notif_flowid),
    .poller_dst_notif_len                  (notif_len),
    .poller_dst_notif_dst_x                (notif_x),
    .poller_dst_notif_dst_y                (notif_y),
    .poller_dst_notif_dst_fbits            (notif_fb),
    .dst_poller_notif_rdy                  (notif_rdy),
    .poller_msg_req_q_wr_req_val           (wr_val),
    .poller_msg_req_q_wr_req_data          (wr_data),
    .msg_req_q_poller_wr_req_rdy           (wr_rdy),
    .poller_active_bitvec_clear_req_val    (clr_val),
    .poller_active_bitvec_clear_req_flowid (clr_fid)
  );

  typedef struct {
    bit                         notify;
    logic [FLOWID_W-1:0]        fid;
    logic [PW-1:0]              len;
    logic [MSG_SRC_X_WIDTH-1:0] x;
    logic [MSG_SRC_Y_WIDTH-1:0] y;
    logic [NOC_FBITS_WIDTH-1:0] fb;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Output side of the scoreboard: every accepted notify/requeue pops one expectation
  logic                pend_clear = 1'b0;
  logic [FLOWID_W-1:0] pend_fid   = '0;
  always @(negedge clk) begin
    if (rst) begin
      pend_clear <= 1'b0;
    end else begin
      if (pend_clear) begin
        check("clear_pulse", 64'(clr_val), 64'd1);
        check("clear_flowid", 64'(clr_fid), 64'(pend_fid));
      end else if (clr_val) begin
        check("unexpected_clear", 64'(clr_val), 64'd0);
      end
      pend_clear <= 1'b0;
      if (notif_val && notif_rdy) begin
        if (sb.size() == 0) check("unexpected_notif", 64'(notif_val), 64'd0);
        else begin
          mon_e = sb.pop_front();
          check("kind_is_notify", 64'(mon_e.notify), 64'd1);
          check("notif_flowid", 64'(notif_flowid), 64'(mon_e.fid));
          check("notif_len", 64'(notif_len), 64'(mon_e.len));
          check("notif_dst", 64'({notif_x, notif_y, notif_fb}), 64'({mon_e.x, mon_e.y, mon_e.fb}));
          pend_clear <= 1'b1;
          pend_fid   <= mon_e.fid;
        end
      end
      if (wr_val && wr_rdy) begin
        if (sb.size() == 0) check("unexpected_requeue", 64'(wr_val), 64'd0);
        else begin
          mon_e = sb.pop_front();
          check("kind_is_requeue", 64'(mon_e.notify), 64'd0);
          check("requeue_flowid", 64'(wr_data), 64'(mon_e.fid));
        end
      end
    end
  end

  // Drives one flow end to end; entered and left just after a rising edge
  task automatic run_flow(input logic [FLOWID_W-1:0] fid, input logic [PW-1:0] len,
                          input logic [7:0] x, input logic [7:0] y, input logic [3:0] fb,
                          input logic [PW:0] head, input logic [PW:0] commit,
                          input int ptr_lat, input int mem_lat, input int stall,
                          input bit exp_notify, input bit chk_lat);
    exp_t e;
    int cyc = 0, deq_cyc = -1, val_cyc = -1, mem_w = -1, ptr_w = -1, stall_cnt = 0, post = 0;
    bit dq = 1'b0, fin = 1'b0;
    e.notify = exp_notify; e.fid = fid; e.len = len; e.x = x; e.y = y; e.fb = fb;
    sb.push_back(e);
    mem_resp_data.length    = len;
    mem_resp_data.dst_x     = x;
    mem_resp_data.dst_y     = y;
    mem_resp_data.dst_fbits = fb;
    ptr_head   = head;
    ptr_commit = commit;
    q_rd_data  = fid;
    while (!fin) begin
      q_rd_val = !dq;
      if (q_rd_val && q_rd_rdy) begin dq = 1'b1; deq_cyc = cyc; end
      if (mem_w > 0) mem_w--;
      mem_resp_val = (mem_w == 0);
      if (mem_resp_val && mem_resp_rdy) mem_w = -2;
      if (mem_req_val && mem_req_rdy) mem_w = mem_lat;
      if (ptr_w > 0) ptr_w--;
      ptr_resp_val = (ptr_w == 0);
      if (ptr_resp_val && ptr_resp_rdy) ptr_w = -2;
      if (ptr_req_val && ptr_req_rdy) ptr_w = ptr_lat;
      notif_rdy = 1'b0;
      wr_rdy    = 1'b0;
      if (notif_val || wr_val) begin
        if (val_cyc < 0) val_cyc = cyc;
        if (stall_cnt >= stall) begin
          notif_rdy = notif_val;
          wr_rdy    = wr_val;
          post      = 2;
        end else if (notif_val) begin
          check("stall_flowid", 64'(notif_flowid), 64'(fid));
          check("stall_len", 64'(notif_len), 64'(len));
          check("stall_dst", 64'({notif_x, notif_y, notif_fb}), 64'({x, y, fb}));
        end
        stall_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (post > 0) begin post--; if (post == 0) fin = 1'b1; end
      if (cyc > 300) begin check("flow_timeout", 64'(cyc), 64'd0); fin = 1'b1; end
    end
    if (chk_lat) check("latency", 64'(val_cyc - deq_cyc), 64'd4);
    q_rd_val = 1'b0; mem_resp_val = 1'b0; ptr_resp_val = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired compared=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW:0]   r_head;
    logic [PW-1:0] r_len;
    int            r_delta;
    rst = 1'b1;
    q_rd_val = 1'b0; q_rd_data = '0;
    mem_req_rdy = 1'b1; ptr_req_rdy = 1'b1;
    mem_resp_val = 1'b0; mem_resp_data = '0;
    ptr_resp_val = 1'b0; ptr_head = '0; ptr_commit = '0;
    notif_rdy = 1'b0; wr_rdy = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_q_rdy", 64'(q_rd_rdy), 64'd0);
    check("reset_vals", 64'({mem_req_val, ptr_req_val, notif_val, wr_val, clr_val}), 64'd0);
    check("reset_resp_rdy", 64'({mem_resp_rdy, ptr_resp_rdy}), 64'd0);
    check("reset_data", 64'({mem_req_addr, notif_len, notif_x, notif_y, notif_fb, clr_fid}), 64'd0);
    rst = 1'b0;
    #1;
    check("post_reset_q_rdy", 64'(q_rd_rdy), 64'd1);
    @(posedge clk); #1;

    run_flow(8'd5, 10'd100, 8'd3, 8'd4, 4'd2, 11'h010, 11'h080, 1, 1, 0, 1'b1, 1'b1);
    run_flow(8'd3, 10'd200, 8'd1, 8'd2, 4'd1, 11'h010, 11'h080, 1, 1, 0, 1'b0, 1'b1);
    run_flow(8'd20, 10'd32, 8'd7, 8'd6, 4'd5, 11'h3F0, 11'h410, 1, 1, 0, 1'b1, 1'b1);
    run_flow(8'd21, 10'd33, 8'd7, 8'd6, 4'd5, 11'h3F0, 11'h410, 1, 1, 0, 1'b0, 1'b0);
    run_flow(8'd9, 10'd64, 8'd10, 8'd11, 4'd12, 11'h000, 11'h100, 1, 4, 5, 1'b1, 1'b0);
    run_flow(8'd30, 10'd1023, 8'd2, 8'd2, 4'd3, 11'h000, 11'h400, 2, 1, 0, 1'b1, 1'b0);
    run_flow(8'd31, 10'd0, 8'd4, 8'd5, 4'd6, 11'h155, 11'h155, 1, 2, 1, 1'b1, 1'b0);
    run_flow(8'd40, 10'd5, 8'd1, 8'd1, 4'd1, 11'h7FE, 11'h002, 3, 1, 2, 1'b0, 1'b0);

    // Reset while both responses are outstanding, then let them arrive anyway
    q_rd_val = 1'b1; q_rd_data = 8'd7;
    @(posedge clk); #1;
    q_rd_val = 1'b0;
    @(posedge clk); #1;
    check("midop_wait_resp_rdy", 64'({mem_resp_rdy, ptr_resp_rdy}), 64'b11);
    rst = 1'b1;
    @(posedge clk); #1;
    check("midop_reset_q_rdy", 64'(q_rd_rdy), 64'd0);
    check("midop_reset_vals", 64'({mem_req_val, ptr_req_val, mem_resp_rdy, ptr_resp_rdy, notif_val, wr_val}), 64'd0);
    rst = 1'b0;
    mem_resp_data = '0;
    ptr_head = 11'h020; ptr_commit = 11'h020;
    mem_resp_val = 1'b1; ptr_resp_val = 1'b1;
    #1;
    check("midop_post_reset_q_rdy", 64'(q_rd_rdy), 64'd1);
    check("midop_data_cleared", 64'({mem_req_addr, notif_flowid, wr_data}), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      check("midop_silent", 64'({mem_req_val, ptr_req_val, mem_resp_rdy, ptr_resp_rdy, notif_val, wr_val, clr_val}), 64'd0);
    end
    mem_resp_val = 1'b0; ptr_resp_val = 1'b0;
    @(posedge clk); #1;
    run_flow(8'd12, 10'd16, 8'd9, 8'd8, 4'd7, 11'h100, 11'h120, 1, 1, 0, 1'b1, 1'b1);

    for (int i = 0; i < 6; i++) begin
      r_head  = 11'($urandom_range(0, 2047));
      r_len   = 10'($urandom_range(0, 1023));
      r_delta = int'($urandom_range(0, 1024));
      run_flow(8'($urandom_range(0, 255)), r_len, 8'($urandom), 8'($urandom), 4'($urandom),
               r_head, r_head + 11'(r_delta), int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
               int'($urandom_range(0, 2)), r_delta >= int'(r_len), 1'b0);
    end

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tcp_msg_poller_sched.md
TCP_MSG_POLLER_SCHED -- requirements
Module: tcp_msg_poller_sched

Interface
REQ-001 SHALL take parameter POLLER_PTR_W, default 0, meaning the receive-buffer byte-offset width; FLOWID_W and MAX_FLOW_CNT come from the package.
REQ-002 SHALL have one clock and a synchronous, active-high reset: clk  in  1  clock; rst  in  1  synchronous active-high reset.
REQ-003 msg_req_q_poller_rd_req_val  in  1  pending-flow queue non-empty.
REQ-004 msg_req_q_poller_rd_req_data  in  FLOWID_W  flowid at queue head.
REQ-005 poller_msg_req_q_rd_req_rdy  out  1  dequeue accept.
REQ-006 poller_msg_req_mem_rd_req_val / _addr / msg_req_mem_poller_rd_req_rdy  out/out/in  1/FLOWID_W/1  request-memory read.
REQ-007 msg_req_mem_poller_rd_resp_val / _data / poller_msg_req_mem_rd_resp_rdy  in/in/out  1/msg_req_mem_struct/1  read response; struct fields length (POLLER_PTR_W), dst_x, dst_y, dst_fbits.
REQ-008 poller_ptr_rd_req_val / _flowid / ptr_poller_rd_req_rdy  out/out/in  1/FLOWID_W/1  rx pointer read.
REQ-009 ptr_poller_rd_resp_val / _head / _commit / poller_ptr_rd_resp_rdy  in/in/in/out  1/POLLER_PTR_W+1/POLLER_PTR_W+1/1  rx head (consumed) and commit (received) pointers, MSB = wrap bit.
REQ-010 poller_dst_notif_val / _flowid / _len / _dst_x / _dst_y / _dst_fbits / dst_poller_notif_rdy  out x6, in  1/FLOWID_W/POLLER_PTR_W/MSG_SRC_X_WIDTH/MSG_SRC_Y_WIDTH/NOC_FBITS_WIDTH/1  data-ready notification.
REQ-011 poller_msg_req_q_wr_req_val / _data / msg_req_q_poller_wr_req_rdy  out/out/in  1/FLOWID_W/1  requeue of unsatisfied flowid.
REQ-012 poller_active_bitvec_clear_req_val / _flowid  out/out  1/FLOWID_W  clear active bit (no ready; always accepted).

Function
REQ-013 SHALL implement FSM IDLE, READ_REQ, WAIT_RESP, DECIDE, NOTIFY, REQUEUE.
REQ-014 IDLE: rd_req_rdy=1; on val&rdy latch flowid, go READ_REQ; else stay.
REQ-015 READ_REQ: assert both read-request vals with latched flowid; each drops independently after its own val&rdy; go WAIT_RESP in the cycle the last is accepted (both same cycle allowed).
REQ-016 WAIT_RESP: each resp_rdy=1 until its response captured, then 0; responses may arrive in either order or together; go DECIDE once both captured.
REQ-017 DECIDE (one cycle): avail = (commit - head) mod 2^(POLLER_PTR_W+1), range 0..2^POLLER_PTR_W; go NOTIFY if avail >= length (zero-extended), else REQUEUE.
REQ-018 length 0 SHALL always satisfy (NOTIFY).
REQ-019 NOTIFY: notif_val=1 with latched flowid/length/dst fields, held stable until rdy; on val&rdy pulse active_bitvec_clear_req_val for exactly that cycle, go IDLE.
REQ-020 REQUEUE: wr_req_val=1 with latched flowid until rdy; on val&rdy go IDLE; no active-bit clear.
REQ-021 Exactly one flowid in flight; no dequeue outside IDLE.
REQ-022 Latency with all rdy high and 1-cycle responses: dequeue in cycle 0, notif/requeue val first high in cycle 4.
REQ-023 Outputs SHALL be registered or decoded from state only; no combinational path from any rdy/val input to an output val.

Reset
REQ-024 rst SHALL force IDLE next cycle; every val and resp_rdy output 0, rd_req_rdy 0 during reset, 1 in the first post-reset IDLE cycle.
REQ-025 Reset mid-operation SHALL discard the latched flowid and captured responses; no request, notification, requeue or clear emitted afterward for it.
REQ-026 Data outputs SHALL be 0 after reset.

Verification
REQ-027 Flow 5, length 100, head 0x010, commit 0x080 (avail 112) -> one notification flowid 5, len 100, clear pulse flowid 5, no requeue.
REQ-028 Flow 3, length 200, avail 112 -> one requeue of flowid 3, no notification, no clear.
REQ-029 Wrap: POLLER_PTR_W=10, head 0x3F0, commit 0x410 (avail 32), length 32 -> notify; length 33 -> requeue.
REQ-030 Pointer response 3 cycles before mem response, notif rdy low 5 cycles -> notif fields stable throughout, single clear pulse on accept.
REQ-031 rst asserted in WAIT_RESP, then responses arrive -> no outputs for that flow; next dequeue proceeds normally.
REQ-032 Full buffer head 0x000, commit 0x400 (POLLER_PTR_W=10, avail 1024), length 1023 -> notify; length 0 with avail 0 -> notify.
